// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types and constants for the 16-bit execute-stage ALU:
//               data width, operation encoding and flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Datapath width
    localparam int ALU_W = 16;

    // Operation select encoding
    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_t;

    // Bit positions inside the {N, Z, C, V, E} flag vector
    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_E = 0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_adder.sv
`default_nettype none
// ============================================================================
// Module      : alu_adder
// Description : ALU_W-bit adder with carry-in and carry-out. Shared by ADD
//               (cin = 0, B) and SUB (cin = 1, ~B).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_adder
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    input  logic             i_cin,
    output logic [ALU_W-1:0] o_sum,
    output logic             o_cout
);

    // One extra bit captures the carry out of the MSB
    logic [ALU_W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{ALU_W{1'b0}}, i_cin};
    assign o_sum  = w_full[ALU_W-1:0];
    assign o_cout = w_full[ALU_W];

endmodule : alu_adder
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : 16-bit two-operand ALU (ADD, SUB, AND, OR) with registered
//               result and registered {N, Z, C, V, E} status flags.
//               One-cycle latency, one operation per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [1:0]       ALUControl,
    output logic [4:0]       Flags,
    output logic [ALU_W-1:0] Res
);

    alu_op_t          w_op;
    logic             w_is_sub;
    logic [ALU_W-1:0] w_add_b;
    logic [ALU_W-1:0] w_sum;
    logic             w_cout;
    logic [ALU_W-1:0] w_res_d;
    logic [4:0]       w_flags_d;
    logic [ALU_W-1:0] r_res_q;
    logic [4:0]       r_flags_q;

    assign w_op     = alu_op_t'(ALUControl);
    assign w_is_sub = (w_op == SUB);

    // Operand mux: subtraction reuses the adder as A + ~B + 1
    assign w_add_b = w_is_sub ? ~B : B;

    alu_adder u_adder (
        .i_a    (A),
        .i_b    (w_add_b),
        .i_cin  (w_is_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Result mux, logic unit and flag generation for the next register value
    always_comb begin
        w_res_d   = '0;
        w_flags_d = '0;
        case (w_op)
            ADD, SUB: w_res_d = w_sum;
            AND:      w_res_d = A & B;
            OR:       w_res_d = A | B;
            default:  w_res_d = '0;
        endcase

        w_flags_d[FLAG_N] = w_res_d[ALU_W-1];
        w_flags_d[FLAG_Z] = (w_res_d == '0);
        w_flags_d[FLAG_E] = (A == B);

        // Carry and overflow only mean something for arithmetic ops. After
        // the operand mux both cases reduce to "same-signed adder inputs,
        // differently-signed sum".
        if (w_op == ADD || w_op == SUB) begin
            w_flags_d[FLAG_C] = w_cout;
            w_flags_d[FLAG_V] = (A[ALU_W-1] == w_add_b[ALU_W-1]) &&
                                (w_sum[ALU_W-1] != A[ALU_W-1]);
        end
    end

    // Output register; reset clears everything, including Z
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_q   <= '0;
            r_flags_q <= '0;
        end else begin
            r_res_q   <= w_res_d;
            r_flags_q <= w_flags_d;
        end
    end

    assign Res   = r_res_q;
    assign Flags = r_flags_q;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Self-checking bench for alu: directed vector table, reset
//               sequences and randomized operations against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic [1:0]  ALUControl;
    logic [4:0]  Flags;
    logic [15:0] Res;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic [4:0]  exp_flags;
    } vec_t;

    vec_t vecs[9];

    alu dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Flags      (Flags),
        .Res        (Res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the arithmetic definitions, using plain integers
    function automatic void model(input logic [1:0] op, input logic [15:0] a,
                                  input logic [15:0] b, output logic [15:0] r,
                                  output logic [4:0] f);
        int ua, ub, sa, sb, full, sfull;
        logic c, v;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0; full = 0;
        case (op)
            2'd0: begin
                full  = ua + ub;
                c     = (full > 65535);
                sfull = sa + sb;
                v     = (sfull > 32767) || (sfull < -32768);
            end
            2'd1: begin
                full  = ua - ub;
                c     = (ua >= ub);
                sfull = sa - sb;
                v     = (sfull > 32767) || (sfull < -32768);
            end
            2'd2: full = ua & ub;
            default: full = ua | ub;
        endcase
        r = full[15:0];
        f = {r[15], (r == 16'h0000), c, v, (a == b)};
    endfunction

    task automatic check(input string name, input logic [15:0] exp_res,
                         input logic [4:0] exp_flags);
        checks++;
        if (Res !== exp_res || Flags !== exp_flags) begin
            errors++;
            $display("FAIL %s: got Res=%h Flags=%b, expected Res=%h Flags=%b",
                     name, Res, Flags, exp_res, exp_flags);
        end
    endtask

    // Present operands away from the active edge, then sample just after it
    task automatic apply(input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        @(negedge clk);
        ALUControl = op; A = a; B = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] er;
        logic [4:0]  ef;
        logic [1:0]  rop;
        logic [15:0] ra, rb;

        vecs[0] = '{"add_eq",       2'd0, 16'h0007, 16'h0007, 16'h000E, 5'b00001};
        vecs[1] = '{"add_carry",    2'd0, 16'hFFFF, 16'h0007, 16'h0006, 5'b00100};
        vecs[2] = '{"add_zero",     2'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b01100};
        vecs[3] = '{"add_ovf",      2'd0, 16'h7FFF, 16'h0001, 16'h8000, 5'b10010};
        vecs[4] = '{"sub_ovf",      2'd1, 16'h8000, 16'h0001, 16'h7FFF, 5'b00110};
        vecs[5] = '{"sub_noborrow", 2'd1, 16'h0007, 16'h0000, 16'h0007, 5'b00100};
        vecs[6] = '{"sub_borrow",   2'd1, 16'h0000, 16'h0001, 16'hFFFF, 5'b10000};
        vecs[7] = '{"and_eq",       2'd2, 16'h0007, 16'h0007, 16'h0007, 5'b00001};
        vecs[8] = '{"or_basic",     2'd3, 16'h00F0, 16'h000F, 16'h00FF, 5'b00000};

        rst_n = 1'b0; A = 16'h1234; B = 16'h1111; ALUControl = 2'd0;

        // Outputs stay cleared across edges while reset is held
        repeat (2) @(posedge clk);
        #1 check("reset_state", 16'h0000, 5'b00000);

        @(negedge clk) rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_flags);
        end

        // Inputs changed between edges are not visible until the next edge
        @(negedge clk);
        A = 16'h0001; B = 16'h0002; ALUControl = 2'd0;
        #1 check("hold_between_edges", 16'h00FF, 5'b00000);
        @(posedge clk);
        #1 check("load_after_change", 16'h0003, 5'b00000);

        // Asynchronous reset between edges with a nonzero result
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_immediate", 16'h0000, 5'b00000);
        @(posedge clk);
        #1 check("reset_hold_edge1", 16'h0000, 5'b00000);
        @(posedge clk);
        #1 check("reset_hold_edge2", 16'h0000, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        A = 16'h0010; B = 16'h0030; ALUControl = 2'd1;
        @(posedge clk);
        model(2'd1, 16'h0010, 16'h0030, er, ef);
        #1 check("first_after_release", er, ef);

        // Randomized operations, with extra weight on equal and corner operands
        for (int i = 0; i < 400; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: rb = ra;
                1: ra = 16'h8000;
                2: rb = 16'hFFFF;
                3: ra = 16'h7FFF;
                default: ;
            endcase
            model(rop, ra, rb, er, ef);
            apply(rop, ra, rb);
            check("random", er, ef);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire
